maxpool_relu_stream: RTL and testbench
======================================

# maxpool_relu_stream

Streaming 2×2 stride-2 max-pool stage that consumes the convolution layer's output feature map one pixel per handshake, in raster order (row 0 col 0 first). It emits one pooled pixel per 2×2 window and optionally applies ReLU. It sits directly downstream of the single-channel conv layer and feeds the next layer's input buffer. A half-width line buffer holds the partial maxima for the even rows.

## Interface
- `DATA_WIDTH`, 16: pixel width, two's-complement signed.
- `H`, 28: input feature-map height; must be even and ≥2.
- `W`, 28: input feature-map width; must be even and ≥2.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: `in_data` holds a conv output pixel.
- `in_ready` out 1: stage accepts the pixel this cycle.
- `in_data` in DATA_WIDTH: conv output pixel.
- `out_valid` out 1: `out_data` holds a pooled pixel.
- `out_ready` in 1: downstream accepts the pixel this cycle.
- `out_data` out DATA_WIDTH: pooled (and optionally rectified) pixel.
- `out_last` out 1: qualifies `out_data` as the final pooled pixel of the frame ((H/2)·(W/2)-th).

## Operation
- An input transfer happens when `in_valid && in_ready`. An output transfer happens when `out_valid && out_ready`.
- Counters `col` (0..W-1) and `row` (0..H-1) advance on each input transfer only.
  - `col` wraps to 0 and increments `row`.
  - After (H-1, W-1), both wrap to 0; the next pixel starts a new frame with no gap.
- `hold` register, DATA_WIDTH signed:
  - Even `col`: `hold <= in_data`.
  - Odd `col`: `pair = max(hold, in_data)`.
- Line buffer `lb[0..W/2-1]`, DATA_WIDTH each.
  - Even `row`, odd `col`: `lb[col>>1] <= pair`.
  - Odd `row`, odd `col`: `result = max(pair, lb[col>>1])`; load the output register with it and set `out_valid`.
  - Set `out_last = (row==H-1 && col==W-1)` on that same load.
- All comparisons are signed. On a tie, either operand is taken (values are equal).
- No arithmetic widening; the output width equals the input width.
- Output register is a 1-deep skid-free buffer: `in_ready = !out_valid || out_ready`.
  - Simultaneous output transfer and new result load: the register takes the new value and `out_valid` stays 1.
  - Output transfer with no new load: `out_valid <= 0` next cycle.
- `in_ready` is combinational from `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `out_valid`.
- `in_ready` may drop only while a pooled pixel is pending and `out_ready == 0`. Input pixels that do not produce output are still gated by this rule, for simplicity.
- `in_data` is ignored when `in_valid == 0`. Counters and `hold` do not change without a transfer.
- Reset (asynchronous, any time, including mid-frame):
  - `row`, `col` and `hold` go to 0.
  - `out_valid`, `out_last` and `out_data` go to 0.
  - `lb` contents are don't-care; they are overwritten before being read.
  - The first pixel after reset deassertion is treated as (0,0).

## Timing
- Latency: `out_valid` rises in the cycle after the input transfer of the odd-row, odd-col pixel (1 cycle).
- Throughput: 1 input pixel/cycle when `out_ready` is held 1. Output rate averages 1 per 4 inputs.
- Backpressure: `out_ready == 0` with `out_valid == 1` forces `in_ready = 0` in the same cycle. Upstream must hold `in_data` and `in_valid`.
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- Line buffer: synchronous write, combinational read (distributed RAM/registers). Read and write never target the same row phase in the same cycle.
- Values after reset: `in_ready = 1`, `out_valid = 0`, `out_last = 0`, `out_data = 0`.

## Configuration
- `MAXPOOL_RELU_EN` defined: `out_data = (result < 0) ? 0 : result`. ReLU is applied after pooling, which is equivalent to applying it before, since max is monotonic.
- `MAXPOOL_RELU_EN` undefined: `out_data = result` (signed max, negatives pass through).
- The handshake, latency and `out_last` behaviour are identical in both builds.

## Test plan
- **Basic window:** H=W=4, frame values 0..15 raster, `out_ready = 1`.
  - Required: outputs 5, 7, 13, 15 in order.
  - `out_last` is 1 only with 15.
  - Each output appears 1 cycle after the pixel at (1,1), (1,3), (3,1), (3,3).
- **Negative / ReLU:** H=W=2, inputs -5, -3, -8, -1.
  - Without the macro: `out_data = -1` (0xFFFF).
  - With `MAXPOOL_RELU_EN`: `out_data = 0`.
- **Backpressure:** 4×4 ramp with `out_ready = 0` for 5 cycles after the first `out_valid`.
  - Required: `in_ready = 0` throughout, `out_data` holds 5, and no input is lost.
  - The output sequence is still 5, 7, 13, 15.
- **Bubbles:** `in_valid` toggles 1/0 every cycle over a 4×4 frame.
  - Required: identical outputs. Counters advance only on transfers.
- **Back-to-back frames:** two 4×4 frames, the second valued 100..115, with no gap.
  - Required: 5, 7, 13, 15, 105, 107, 113, 115.
  - `out_last` is asserted on 15 and on 115.
- **Mid-frame reset:** assert `reset` after 6 pixels of a 4×4 frame, then send a full 0..15 frame.
  - Required: `out_valid = 0` during reset.
  - The next outputs are exactly 5, 7, 13, 15.

Source files
------------

// File: rtl/maxpool_relu_stream.sv
// maxpool_relu_stream: streaming 2x2 stride-2 max-pool with a half-width line buffer.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_relu_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int H = 28,
    parameter int W = 28
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [DATA_WIDTH-1:0] out_data,
    output logic                         out_last
);
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);
    localparam int LW = (CW > 1) ? CW - 1 : 1;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [LW-1:0] li;
    logic signed [DATA_WIDTH-1:0] hold, pair, lb_rd, result, pooled;
    logic signed [DATA_WIDTH-1:0] lb [2**LW];
    logic xfer, last_col, last_row;

    always_comb begin
        in_ready = !out_valid || out_ready;
        xfer = in_valid && in_ready;
        last_col = col == CW'(W - 1);
        last_row = row == RW'(H - 1);
        li = LW'(col >> 1);
        lb_rd = lb[li];
        pair = (in_data > hold) ? in_data : hold;
        result = (pair > lb_rd) ? pair : lb_rd;
`ifdef MAXPOOL_RELU_EN
        pooled = (result < 0) ? '0 : result;
`else
        pooled = result;
`endif
    end

    // even rows park their horizontal pair maxima for the odd row below
    always_ff @(posedge clk)
        if (xfer && col[0] && !row[0]) lb[li] <= pair;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            hold <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_data <= '0;
        end else begin
            if (xfer) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) row <= last_row ? '0 : row + 1'b1;
                if (!col[0]) hold <= in_data;
            end
            if (xfer && col[0] && row[0]) begin
                out_valid <= 1'b1;
                out_data <= pooled;
                out_last <= last_row && last_col;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_maxpool_relu_stream.sv
// tb_maxpool_relu_stream: directed and random frames checked against a 2D-array pooling model.
module tb_maxpool_relu_stream;
    localparam int DW = 16;
    localparam int H = 4;
    localparam int W = 4;
    logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, out_last;
    logic [DW-1:0] in_data = '0, out_data;
    int n_cmp = 0, n_bad = 0;
    int fr [H][W];
    int pix_n = 0;
    logic [DW-1:0] exp_d [$];
    logic exp_l [$];
    int obs [$];
    logic obs_l [$];
    bit rand_or = 0;

    always #5 clk = ~clk;

    maxpool_relu_stream #(.DATA_WIDTH(DW), .H(H), .W(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    function automatic int relu(int x);
`ifdef MAXPOOL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // raster position from the pixel count; pool each finished 2x2 window
    task automatic model_push(int v);
        int r, c, m;
        r = pix_n / W;
        c = pix_n % W;
        fr[r][c] = v;
        if (r % 2 == 1 && c % 2 == 1) begin
            m = fr[r-1][c-1];
            if (fr[r-1][c] > m) m = fr[r-1][c];
            if (fr[r][c-1] > m) m = fr[r][c-1];
            if (fr[r][c] > m) m = fr[r][c];
            exp_d.push_back(DW'(relu(m)));
            exp_l.push_back(pix_n == H * W - 1);
        end
        pix_n = (pix_n + 1) % (H * W);
    endtask

    task automatic put(int v, int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1;
        in_data = DW'(v);
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin t++; @(negedge clk); end
        if (t >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL in_stall: in_ready low for %0d cycles, expected release", t);
        end else begin
            @(posedge clk); #1;
            model_push(v);
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_d.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d outputs outstanding, expected 0", exp_d.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1;
        exp_d.delete(); exp_l.delete();
        pix_n = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_in_ready", in_ready, 1);
        end
        @(posedge clk); #2;
        reset = 0;
    endtask

    task automatic chk_seq(string name, int e [$], int last_at [$]);
        chk({name, "_count"}, obs.size(), e.size());
        for (int i = 0; i < e.size() && i < obs.size(); i++) begin
            chk(name, obs[i], e[i]);
            chk({name, "_last"}, obs_l[i], (i == last_at[0] || i == last_at[last_at.size()-1]) ? 1 : 0);
        end
    endtask

    task automatic ramp(int base, int gap);
        for (int i = 0; i < H * W; i++) put(base + i, gap);
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    end

    // every-cycle comparison against the model queue
    initial begin
        bit hv;
        logic [DW-1:0] hd;
        logic hl;
        hv = 0; hd = '0; hl = 0;
        forever begin
            @(negedge clk);
            if (reset) hv = 0;
            else begin
                chk("out_valid", out_valid, exp_d.size() != 0);
                chk("in_ready", in_ready, (exp_d.size() == 0 || out_ready) ? 1 : 0);
                if (hv) begin
                    chk("stall_data", out_data, hd);
                    chk("stall_last", out_last, hl);
                end
                if (out_valid && out_ready && exp_d.size() != 0) begin
                    obs.push_back(int'($signed(out_data)));
                    obs_l.push_back(out_last);
                    chk("out_data", out_data, exp_d.pop_front());
                    chk("out_last", out_last, exp_l.pop_front());
                end
                hv = out_valid && !out_ready;
                hd = out_data;
                hl = out_last;
            end
        end
    end

    initial begin
        int e [$];
        int t;
        int neg [16];
        neg = '{-5, -3, 2, 3, -8, -1, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        @(negedge clk);
        chk("init_out_valid", out_valid, 0);
        chk("init_out_last", out_last, 0);
        chk("init_out_data", out_data, 0);
        chk("init_in_ready", in_ready, 1);
        @(posedge clk); #2;
        reset = 0;

        obs.delete(); obs_l.delete();
        ramp(0, 0);
        drain();
        e = {5, 7, 13, 15};
        chk_seq("basic", e, '{3});

        obs.delete(); obs_l.delete();
        for (int i = 0; i < 16; i++) put(neg[i], 0);
        drain();
`ifdef MAXPOOL_RELU_EN
        chk("neg_window", obs[0], 0);
`else
        chk("neg_window", obs[0], -1);
`endif
        chk("neg_second", obs[1], 7);

        obs.delete(); obs_l.delete();
        fork
            ramp(0, 0);
            begin
                t = 0;
                do begin @(posedge clk); #1; t++; end while (!out_valid && t < 50);
                out_ready = 0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold5", out_data, 5);
                end
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        drain();
        chk_seq("backpressure", e, '{3});

        obs.delete(); obs_l.delete();
        ramp(0, 1);
        drain();
        chk_seq("bubbles", e, '{3});

        obs.delete(); obs_l.delete();
        ramp(0, 0);
        ramp(100, 0);
        drain();
        e = {5, 7, 13, 15, 105, 107, 113, 115};
        chk_seq("b2b", e, '{3, 7});

        for (int i = 0; i < 6; i++) put(i, 0);
        do_reset();
        obs.delete(); obs_l.delete();
        ramp(0, 0);
        drain();
        e = {5, 7, 13, 15};
        chk_seq("midreset", e, '{3});

        rand_or = 1;
        for (int f = 0; f < 12; f++)
            for (int i = 0; i < H * W; i++) begin
                int v;
                v = $signed(DW'($urandom));
                put(v, ($urandom_range(0, 2) == 0) ? 1 : 0);
            end
        rand_or = 0;
        out_ready = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
